// File: rtl/div_unit.sv
// div_unit -- iterative 32-bit integer divider (DIV / DIVU).
//
// Radix-2 restoring divide on operand magnitudes. One quotient bit is produced
// per cycle, MSB first, over 32 CALC cycles. The results are then sign-corrected
// and registered in DONE.
//
// Ports:
//   clk        rising-edge clock
//   resetn     synchronous active-low reset
//   div_start  request; accepted in IDLE when div_cancel=0
//   div_signed 1 = signed divide, 0 = unsigned (sampled at acceptance)
//   div_opr1   dividend (sampled at acceptance)
//   div_opr2   divisor  (sampled at acceptance)
//   div_cancel flush; returns to IDLE and discards any operation
//   div_ready  high in IDLE
//   div_done   one-cycle pulse in DONE; div_quo/div_rem valid
//   div_quo    quotient (held until the next DONE)
//   div_rem    remainder (held until the next DONE)
//
// Optional feature macro: DIV_ZERO_FAST_EN
//   When defined, a zero divisor skips CALC. The unit goes straight to DONE
//   with quo=all-ones and rem=dividend, and no sign correction is applied.

module div_unit (
  input  logic        clk,
  input  logic        resetn,
  input  logic        div_start,
  input  logic        div_signed,
  input  logic [31:0] div_opr1,
  input  logic [31:0] div_opr2,
  input  logic        div_cancel,
  output logic        div_ready,
  output logic        div_done,
  output logic [31:0] div_quo,
  output logic [31:0] div_rem
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [4:0]  cnt_q,   cnt_d;
  logic [31:0] acc_q,   acc_d;    // partial remainder
  logic [31:0] qsh_q,   qsh_d;    // dividend shifts out of the top, quotient shifts in
  logic [31:0] dvsr_q,  dvsr_d;   // divisor magnitude
  logic        sgn_q,   sgn_d;
  logic        s1_q,    s1_d;     // dividend sign
  logic        s2_q,    s2_d;     // divisor sign
  logic [31:0] quo_q,   quo_d;
  logic [31:0] rem_q,   rem_d;

  logic [32:0] trial;
  logic        qbit;
  logic [31:0] acc_nxt, qsh_nxt, mag1, mag2;

  always_comb begin
    // The partial remainder always stays below the divisor. So the shifted
    // value is below 2*divisor, and bit 32 of the 33-bit difference is a true borrow.
    trial   = {acc_q, qsh_q[31]} - {1'b0, dvsr_q};
    qbit    = ~trial[32];
    acc_nxt = qbit ? trial[31:0] : {acc_q[30:0], qsh_q[31]};
    qsh_nxt = {qsh_q[30:0], qbit};

    mag1 = (div_signed && div_opr1[31]) ? -div_opr1 : div_opr1;
    mag2 = (div_signed && div_opr2[31]) ? -div_opr2 : div_opr2;

    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    qsh_d   = qsh_q;
    dvsr_d  = dvsr_q;
    sgn_d   = sgn_q;
    s1_d    = s1_q;
    s2_d    = s2_q;
    quo_d   = quo_q;
    rem_d   = rem_q;

    case (state_q)
      S_IDLE: begin
        if (div_start) begin
          state_d = S_CALC;
          cnt_d   = 5'd0;
          acc_d   = 32'd0;
          qsh_d   = mag1;
          dvsr_d  = mag2;
          sgn_d   = div_signed;
          s1_d    = div_signed & div_opr1[31];
          s2_d    = div_signed & div_opr2[31];
`ifdef DIV_ZERO_FAST_EN
          if (div_opr2 == 32'd0) begin
            state_d = S_DONE;
            quo_d   = 32'hFFFF_FFFF;
            rem_d   = div_opr1;
          end
`endif
        end
      end
      S_CALC: begin
        acc_d = acc_nxt;
        qsh_d = qsh_nxt;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d = S_DONE;
          quo_d   = (sgn_q && (s1_q ^ s2_q)) ? -qsh_nxt : qsh_nxt;
          rem_d   = (sgn_q && s1_q) ? -acc_nxt : acc_nxt;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // A flush beats both acceptance and the final CALC step. The result
    // registers keep whatever they held before.
    if (div_cancel) begin
      state_d = S_IDLE;
      cnt_d   = 5'd0;
      quo_d   = quo_q;
      rem_d   = rem_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      cnt_q   <= 5'd0;
      acc_q   <= 32'd0;
      qsh_q   <= 32'd0;
      dvsr_q  <= 32'd0;
      sgn_q   <= 1'b0;
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      quo_q   <= 32'd0;
      rem_q   <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      qsh_q   <= qsh_d;
      dvsr_q  <= dvsr_d;
      sgn_q   <= sgn_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
    end
  end

  assign div_ready = (state_q == S_IDLE);
  assign div_done  = (state_q == S_DONE);
  assign div_quo   = quo_q;
  assign div_rem   = rem_q;

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit. The issue task pushes the expected result and
// the expected done cycle into a queue. The monitor pops on every div_done and
// compares. Between pulses it checks that the outputs hold steady.
module tb_div_unit;

  logic        clk = 1'b0;
  logic        resetn, div_start, div_signed, div_cancel;
  logic [31:0] div_opr1, div_opr2;
  logic        div_ready, div_done;
  logic [31:0] div_quo, div_rem;

  div_unit dut (
    .clk(clk), .resetn(resetn), .div_start(div_start), .div_signed(div_signed),
    .div_opr1(div_opr1), .div_opr2(div_opr2), .div_cancel(div_cancel),
    .div_ready(div_ready), .div_done(div_done), .div_quo(div_quo), .div_rem(div_rem)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    int          t;
  } exp_t;

  exp_t        sb[$];
  int          cyc = 0;
  int          n_vec = 0;
  int          n_err = 0;
  bit          mon_en = 1'b0;
  logic [31:0] hold_q = 32'd0;
  logic [31:0] hold_r = 32'd0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: plain magnitude arithmetic, then sign rules.
  function automatic exp_t model(input bit s, input logic [31:0] a, input logic [31:0] b,
                                 input int e0);
    exp_t        m;
    bit          na, nb;
    logic [31:0] ma, mb, qm, rm;
    na = s && a[31];
    nb = s && b[31];
    ma = na ? 32'd0 - a : a;
    mb = nb ? 32'd0 - b : b;
    if (mb == 32'd0) begin
      qm = 32'hFFFF_FFFF;
      rm = ma;
    end else begin
      qm = ma / mb;
      rm = ma % mb;
    end
    m.q = (na != nb) ? 32'd0 - qm : qm;
    m.r = na ? 32'd0 - rm : rm;
    m.t = e0 + 32;
`ifdef DIV_ZERO_FAST_EN
    if (b == 32'd0) begin
      m.q = 32'hFFFF_FFFF;
      m.r = a;
      m.t = e0;
    end
`endif
    return m;
  endfunction

  // Monitor
  always @(negedge clk) begin
    if (mon_en) begin
      if (div_done === 1'b1) begin
        if (sb.size() == 0) begin
          chk("spurious_done", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("quo", div_quo, e.q);
          chk("rem", div_rem, e.r);
          chk("done_cycle", 32'(cyc), 32'(e.t));
          hold_q = e.q;
          hold_r = e.r;
        end
      end else begin
        chk("hold_quo", div_quo, hold_q);
        chk("hold_rem", div_rem, hold_r);
      end
    end
  end

  // Called just after a negedge; returns just after the next negedge.
  task automatic issue(input bit s, input logic [31:0] a, input logic [31:0] b,
                       input bit push, output int e0);
    int w;
    w = 0;
    while (div_ready !== 1'b1 && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (div_ready !== 1'b1) chk("ready_timeout", {31'd0, div_ready}, 32'd1);
    div_start  = 1'b1;
    div_signed = s;
    div_opr1   = a;
    div_opr2   = b;
    e0 = cyc + 1;
    if (push) sb.push_back(model(s, a, b, e0));
    @(negedge clk);
    div_start = 1'b0;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0:       return 32'd0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int e0;
    resetn = 1'b0; div_start = 1'b1; div_cancel = 1'b0; div_signed = 1'b0;
    div_opr1 = 32'd0; div_opr2 = 32'd0;
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'd0, div_ready}, 32'd1);
    chk("rst_done",  {31'd0, div_done},  32'd0);
    chk("rst_quo", div_quo, 32'd0);
    chk("rst_rem", div_rem, 32'd0);
    div_start = 1'b0;
    resetn = 1'b1;
    mon_en = 1'b1;

    // Directed cases
    issue(0, 32'd100, 32'd7, 1, e0);
    issue(1, 32'hFFFF_FFF9, 32'd2, 1, e0);
    issue(1, 32'd7, 32'hFFFF_FFFE, 1, e0);
    issue(1, 32'h8000_0000, 32'hFFFF_FFFF, 1, e0);
    issue(0, 32'h8000_0000, 32'hFFFF_FFFF, 1, e0);
    issue(0, 32'd5, 32'd0, 1, e0);
    issue(1, 32'hFFFF_FFFB, 32'd0, 1, e0);

    // Cancel at CALC cycle 10, then an immediate new request
    issue(0, 32'd100, 32'd7, 0, e0);
    while (cyc < e0 + 10) @(negedge clk);
    div_cancel = 1'b1;
    div_start  = 1'b1;
    @(negedge clk);
    div_cancel = 1'b0;
    div_start  = 1'b0;
    chk("cancel_ready", {31'd0, div_ready}, 32'd1);
    chk("cancel_done",  {31'd0, div_done},  32'd0);
    issue(0, 32'd9, 32'd3, 1, e0);

    // Start held with changing operands during CALC must be ignored
    issue(0, 32'd1000, 32'd9, 1, e0);
    for (int i = 0; i < 25; i++) begin
      div_start = 1'b1;
      div_opr1  = $urandom;
      div_opr2  = $urandom;
      @(negedge clk);
    end
    div_start = 1'b0;

    // Reset at CALC cycle 20 with start and cancel asserted
    issue(1, 32'd100, 32'd7, 0, e0);
    while (cyc < e0 + 20) @(negedge clk);
    resetn = 1'b0; div_start = 1'b1; div_cancel = 1'b1;
    @(posedge clk);
    #1;
    hold_q = 32'd0;
    hold_r = 32'd0;
    @(negedge clk);
    chk("rstmid_ready", {31'd0, div_ready}, 32'd1);
    chk("rstmid_done",  {31'd0, div_done},  32'd0);
    chk("rstmid_quo", div_quo, 32'd0);
    chk("rstmid_rem", div_rem, 32'd0);
    resetn = 1'b1; div_start = 1'b0; div_cancel = 1'b0;
    repeat (40) @(negedge clk);

    // Randomized traffic
    for (int i = 0; i < 40; i++) begin
      issue(1'($urandom), pick(), pick(), 1, e0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    begin
      int w;
      w = 0;
      while (sb.size() != 0 && w < 200) begin
        @(negedge clk);
        w++;
      end
      if (sb.size() != 0) chk("drain_timeout", 32'(sb.size()), 32'd0);
    end
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state changes on rising edge.
REQ-002 SHALL have port: resetn  input  1  reset, synchronous and active-low.
REQ-003 SHALL have port: div_start  input  1  request a divide; accepted only when div_ready=1.
REQ-004 SHALL have port: div_signed  input  1  1 = DIV (two's complement), 0 = DIVU; sampled at acceptance.
REQ-005 SHALL have port: div_opr1  input  32  dividend; sampled at acceptance.
REQ-006 SHALL have port: div_opr2  input  32  divisor; sampled at acceptance.
REQ-007 SHALL have port: div_cancel  input  1  pipeline flush; aborts any operation in progress.
REQ-008 SHALL have port: div_ready  output  1  unit is idle and can accept div_start.
REQ-009 SHALL have port: div_done  output  1  one-cycle pulse; div_quo and div_rem are valid.
REQ-010 SHALL have port: div_quo  output  32  quotient (LO).
REQ-011 SHALL have port: div_rem  output  32  remainder (HI).

Function
REQ-012 SHALL implement three states: IDLE, CALC and DONE; div_ready=1 only in IDLE.
REQ-013 SHALL accept a request at an edge where state=IDLE, div_start=1 and div_cancel=0, and SHALL then latch signedness, operand signs and operand magnitudes.
REQ-014 Magnitude: if div_signed=1 and the operand MSB=1, the magnitude SHALL be the two's-complement negation of the operand; otherwise it SHALL be the raw operand.
REQ-015 CALC SHALL perform a radix-2 restoring divide on magnitudes: one quotient bit per cycle, MSB first, using a 33-bit trial subtract, for exactly 32 cycles, counted by a 5-bit counter.
REQ-016 The 32nd CALC edge SHALL enter DONE and register sign-corrected results into div_quo and div_rem.
REQ-017 div_done SHALL be 1 for exactly the one cycle spent in DONE; the next edge SHALL return to IDLE.
REQ-018 Latency: if acceptance occurs at edge E0, div_done SHALL be high in the cycle after edge E32 (33 cycles from the start cycle).
REQ-019 Signed sign correction: the quotient SHALL be negated iff the operand signs differ; the remainder SHALL take the dividend's sign.
REQ-020 div_signed=1 with 0x80000000 / 0xFFFFFFFF SHALL give quo=0x80000000 and rem=0, with no exception or flag.
REQ-021 div_quo and div_rem SHALL hold their last values until the next DONE, and SHALL not change during CALC.
REQ-022 div_start while state is not IDLE SHALL be ignored; operand changes after acceptance SHALL have no effect.
REQ-023 div_cancel=1 at any edge SHALL force IDLE and clear the counter.
  - No div_done SHALL follow, and div_quo/div_rem SHALL keep their prior values.
  - div_cancel SHALL take priority over div_start and over the CALC-to-DONE transition on the same edge.
REQ-024 A new request MAY be accepted on the edge that leaves DONE only if the state is IDLE at that edge; that is, back-to-back requests require one IDLE cycle.

Reset
REQ-025 resetn=0 at an edge SHALL force the following, regardless of div_start or div_cancel:
  - state=IDLE, counter=0;
  - div_done=0, div_ready=1;
  - div_quo=0, div_rem=0.
REQ-026 Reset mid-CALC SHALL discard the operation, with no div_done pulse.

Configuration
REQ-027 Macro DIV_ZERO_FAST_EN, when defined:
  - an accepted request with div_opr2=0 SHALL go directly from IDLE to DONE, so div_done is high in the cycle after E0;
  - results SHALL be quo=0xFFFFFFFF and rem=div_opr1, with no sign correction.
REQ-028 Without DIV_ZERO_FAST_EN, a divisor of 0 SHALL follow the normal 32-cycle path (REQ-018).
  - Results are those of the restoring algorithm: magnitude quotient 0xFFFFFFFF and remainder |dividend|, then REQ-019 sign correction.

Verification
REQ-029 DIVU 100/7 -> div_done exactly 33 cycles after start; quo=14, rem=2.
REQ-030 DIV 0xFFFFFFF9(-7)/2 -> quo=0xFFFFFFFD(-3), rem=0xFFFFFFFF(-1); DIV 7/0xFFFFFFFE(-2) -> quo=0xFFFFFFFD, rem=1.
REQ-031 DIV 0x80000000/0xFFFFFFFF -> quo=0x80000000, rem=0; DIVU of the same operands -> quo=0, rem=0x80000000.
REQ-032 DIVU 5/0 -> with DIV_ZERO_FAST_EN: done 1 cycle after start, quo=0xFFFFFFFF, rem=5; without it: done after 33 cycles, quo=0xFFFFFFFF, rem=5.
REQ-033 Start 100/7, then div_cancel at CALC cycle 10 -> no div_done, div_ready=1 on the next cycle, outputs unchanged; an immediate new 9/3 -> quo=3, rem=0.
REQ-034 resetn=0 at CALC cycle 20 -> next cycle div_ready=1, div_done=0, quo=rem=0; a div_start held during CALC is never accepted.
